npu_banked_ram: RTL and testbench
=================================

Name: npu_banked_ram

Overview:
- Parametrised successor to the fixed 2048x8 NPU memory: N generic banks of configurable depth and width behind one single-port request interface.
- Adds a valid/ready request handshake, an optional output register stage, and an auto-incrementing read-burst engine that streams sequential words across bank boundaries.
- Sits between the NPU address decoder (mem_adr/reg_adr split) and the NPU datapath. The datapath consumes read data without backpressure.

Parameters:
- NUM_BANKS, 8, number of banks; power of 2, at least 2.
- BANK_DEPTH, 256, words per bank; power of 2.
- WIDTH, 8, data width in bits.
- MEMSEL_W, 6, width of mem_adr.
- REGSEL_W, 14, width of reg_adr; must be at least BANK_AW+ROW_AW.
- MEM_ADDR, 0, mem_adr value that enables writes to this instance.
- OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- BLEN_W, 8, width of burst_len.
- Derived, not overridable: ROW_AW = clog2(BANK_DEPTH), BANK_AW = clog2(NUM_BANKS), DEPTH = NUM_BANKS*BANK_DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- we  in  1  1 = single write, 0 = read burst.
- mem_adr  in  MEMSEL_W  memory select.
- reg_adr  in  REGSEL_W  word address; bank = [BANK_AW+ROW_AW-1:ROW_AW], row = [ROW_AW-1:0], upper bits ignored.
- din  in  WIDTH  write data.
- burst_len  in  BLEN_W  read beats minus 1; ignored on writes.
- dout  out  WIDTH  read data.
- rsp_valid  out  1  dout valid this cycle.
- busy  out  1  burst in progress.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, busy=0, dout=0. FSM goes to IDLE, address counter and beat counter go to 0. Array contents are not reset.
- FSM states: IDLE and BURST.
- IDLE: req_ready=1.
  - Accepted write: if mem_adr==MEM_ADDR, the addressed bank row is written with din at that edge. Otherwise the write is dropped silently. No response either way. Stay in IDLE.
  - Accepted read: beat 0 is issued at the accept edge, regardless of mem_adr (reads are never gated). addr_cnt := address+1 mod DEPTH. If burst_len==0, stay in IDLE. Otherwise remain_cnt := burst_len and go to BURST.
- BURST: req_ready=0, busy=1.
  - One read beat is issued per cycle at addr_cnt, then addr_cnt increments.
  - addr_cnt wraps from DEPTH-1 to 0; crossing a bank boundary adds no gap cycle.
  - remain_cnt decrements each beat. On the beat where remain_cnt==1, go to IDLE; req_ready=1 from the next cycle.
- Beat count: total beats = burst_len+1. Maximum burst 2^BLEN_W beats; a burst longer than DEPTH rereads wrapped data.
- Bank enable: exactly one bank is enabled per access. Per-bank enable = request/beat active && bank index match && (read || mem_adr==MEM_ADDR).
- Read data path:
  - The bank index of each issued beat is registered and selects the bank output at the following cycle.
  - OUT_REG=0: rsp_valid/dout are valid 1 cycle after issue.
  - OUT_REG=1: rsp_valid/dout are valid 2 cycles after issue.
  - A burst of N beats yields N consecutive rsp_valid cycles.
  - dout holds its last value when rsp_valid=0.
- Ordering: a write accepted in cycle T is visible to a read issued in T+1 or later. A write cannot be accepted during BURST.
- Reset asserted mid-burst: the burst aborts immediately and in-flight responses are discarded (rsp_valid=0). Array contents written before reset are retained.
- req_valid held with req_ready=0 is not accepted. The requester must keep request fields stable until acceptance.

Test Plan:
- Defaults. Write 0xA5 to reg_adr 0x005 (bank 0) and 0x3C to 0x705 (bank 7), mem_adr=0. Read 0x705 with burst_len=0 -> rsp_valid one cycle after accept, dout=0x3C. Read 0x005 -> dout=0xA5.
- Write with mem_adr=1 to 0x010 holding 0x11 -> read of 0x010 still returns 0x11. Repeat with mem_adr=0 -> the read returns the new data.
- Burst across a bank boundary: preload 0x0FE=0x01, 0x0FF=0x02, 0x100=0x03, 0x101=0x04. Read 0x0FE with burst_len=3 -> 4 consecutive rsp_valid cycles with data 01,02,03,04. busy=1 and req_ready=0 for 3 cycles after accept.
- Wrap-around: preload 0x7FF=0x77, 0x000=0x88. Burst from 0x7FF with burst_len=1 -> dout 0x77 then 0x88.
- OUT_REG=1 with NUM_BANKS=4, BANK_DEPTH=512, WIDTH=16: write 0xBEEF to 0x3FF, then read it -> rsp_valid exactly 2 cycles after accept, dout=0xBEEF.
- Assert rst_n low during the 3rd beat of an 8-beat burst -> rsp_valid=0, busy=0, req_ready=1 immediately. After release, previously written data reads back unchanged.

Source files
------------

// File: rtl/npu_banked_ram.sv
// Banked single-port NPU memory with valid/ready requests and an auto-incrementing read-burst engine.
// Read data returns 1 cycle after issue (OUT_REG=0) or 2 cycles after issue (OUT_REG=1).
module npu_banked_ram #(
    parameter int NUM_BANKS  = 8,
    parameter int BANK_DEPTH = 256,
    parameter int WIDTH      = 8,
    parameter int MEMSEL_W   = 6,
    parameter int REGSEL_W   = 14,
    parameter int MEM_ADDR   = 0,
    parameter int OUT_REG    = 0,
    parameter int BLEN_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                we,
    input  logic [MEMSEL_W-1:0] mem_adr,
    input  logic [REGSEL_W-1:0] reg_adr,
    input  logic [WIDTH-1:0]    din,
    input  logic [BLEN_W-1:0]   burst_len,
    output logic [WIDTH-1:0]    dout,
    output logic                rsp_valid,
    output logic                busy
);
    localparam int ROW_AW  = $clog2(BANK_DEPTH);
    localparam int BANK_AW = $clog2(NUM_BANKS);
    localparam int AW      = BANK_AW + ROW_AW;

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    state_t            state;
    logic [AW-1:0]     addr_cnt;
    logic [BLEN_W-1:0] remain_cnt;

    logic              accept;
    logic              wr_en;
    logic              iss_valid;
    logic [AW-1:0]     req_addr;
    logic [AW-1:0]     iss_addr;
    logic [BANK_AW-1:0] acc_bank;
    logic [ROW_AW-1:0]  acc_row;

    logic [WIDTH-1:0]   bank_rd [NUM_BANKS];
    logic [WIDTH-1:0]   rd_mux;
    logic               rd_vld_q;
    logic [BANK_AW-1:0] bank_sel_q;
    logic [WIDTH-1:0]   hold_q;

    assign accept   = req_valid && req_ready;
    assign wr_en    = accept && we && (mem_adr == MEMSEL_W'(MEM_ADDR));
    assign req_addr = reg_adr[AW-1:0];

    generate
        if (REGSEL_W > AW) begin : g_upper
            logic unused_upper;
            assign unused_upper = ^reg_adr[REGSEL_W-1:AW];
        end
    endgenerate

    // A single address serves both the request path (IDLE) and the burst counter (BURST).
    always_comb begin
        iss_valid = 1'b0;
        iss_addr  = req_addr;
        if (state == BURST) begin
            iss_valid = 1'b1;
            iss_addr  = addr_cnt;
        end else if (accept && !we) begin
            iss_valid = 1'b1;
        end
    end

    assign acc_bank = iss_addr[AW-1:ROW_AW];
    assign acc_row  = iss_addr[ROW_AW-1:0];

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [WIDTH-1:0] mem [BANK_DEPTH];
            logic [WIDTH-1:0] rd_q;
            logic             bank_en;

            assign bank_en = (iss_valid || wr_en) && (acc_bank == BANK_AW'(b));

            always_ff @(posedge clk) begin
                if (bank_en) begin
                    if (wr_en) begin
                        mem[acc_row] <= din;
                    end else begin
                        rd_q <= mem[acc_row];
                    end
                end
            end

            assign bank_rd[b] = rd_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            remain_cnt <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !we) begin
                        addr_cnt <= iss_addr + AW'(1);
                        if (burst_len != '0) begin
                            remain_cnt <= burst_len;
                            state      <= BURST;
                            req_ready  <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    addr_cnt   <= iss_addr + AW'(1);
                    remain_cnt <= remain_cnt - BLEN_W'(1);
                    if (remain_cnt == BLEN_W'(1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rd_mux = bank_rd[bank_sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q   <= 1'b0;
            bank_sel_q <= '0;
            hold_q     <= '0;
        end else begin
            rd_vld_q <= iss_valid;
            if (iss_valid) begin
                bank_sel_q <= acc_bank;
            end
            if (rd_vld_q) begin
                hold_q <= rd_mux;
            end
        end
    end

    // hold_q doubles as the output register and as the hold value for the unregistered path.
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic vld2_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld2_q <= 1'b0;
                end else begin
                    vld2_q <= rd_vld_q;
                end
            end
            assign dout      = hold_q;
            assign rsp_valid = vld2_q;
        end else begin : g_ocomb
            assign dout      = rd_vld_q ? rd_mux : hold_q;
            assign rsp_valid = rd_vld_q;
        end
    endgenerate
endmodule

// File: tb/tb_npu_banked_ram.sv
// Directed bench for npu_banked_ram: default instance plus an OUT_REG=1, 4x512x16 instance.
module tb_npu_banked_ram;
    logic clk;
    logic rst_n;

    logic        req_valid, req_ready, we, rsp_valid, busy;
    logic [5:0]  mem_adr;
    logic [13:0] reg_adr;
    logic [7:0]  din, burst_len, dout;

    logic        r_req_valid, r_req_ready, r_we, r_rsp_valid, r_busy;
    logic [5:0]  r_mem_adr;
    logic [13:0] r_reg_adr;
    logic [15:0] r_din, r_dout;
    logic [7:0]  r_burst_len;

    int n_checks = 0;
    int n_fails  = 0;
    logic [7:0] exp_q [8];

    npu_banked_ram u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .we(we), .mem_adr(mem_adr), .reg_adr(reg_adr), .din(din),
        .burst_len(burst_len), .dout(dout), .rsp_valid(rsp_valid), .busy(busy)
    );

    npu_banked_ram #(.NUM_BANKS(4), .BANK_DEPTH(512), .WIDTH(16), .OUT_REG(1)) u_dut_r (
        .clk(clk), .rst_n(rst_n), .req_valid(r_req_valid), .req_ready(r_req_ready),
        .we(r_we), .mem_adr(r_mem_adr), .reg_adr(r_reg_adr), .din(r_din),
        .burst_len(r_burst_len), .dout(r_dout), .rsp_valid(r_rsp_valid), .busy(r_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [13:0] addr, input logic [7:0] data, input logic [5:0] madr);
        @(negedge clk);
        req_valid = 1'b1; we = 1'b1; mem_adr = madr; reg_adr = addr; din = data;
        @(posedge clk);
        #1 req_valid = 1'b0; we = 1'b0;
    endtask

    // Expected data comes from exp_q[0..blen].
    task automatic rd_burst(input string tag, input logic [13:0] addr, input logic [7:0] blen);
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; mem_adr = 6'd0; reg_adr = addr; burst_len = blen;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i <= int'(blen); i++) begin
            @(negedge clk);
            check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
            check_val({tag, "_dout"}, 32'(dout), 32'(exp_q[i]));
            check_val({tag, "_busy"}, 32'(busy), (i < int'(blen)) ? 32'd1 : 32'd0);
            check_val({tag, "_req_ready"}, 32'(req_ready), (i < int'(blen)) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        check_val({tag, "_rsp_idle"}, 32'(rsp_valid), 32'd0);
        check_val({tag, "_dout_hold"}, 32'(dout), 32'(exp_q[blen]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 0; we = 0; mem_adr = 0; reg_adr = 0; din = 0; burst_len = 0;
        r_req_valid = 0; r_we = 0; r_mem_adr = 0; r_reg_adr = 0; r_din = 0; r_burst_len = 0;
        repeat (3) @(negedge clk);
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_dout", 32'(dout), 32'd0);
        check_val("rst_r_rsp_valid", 32'(r_rsp_valid), 32'd0);
        check_val("rst_r_dout", 32'(r_dout), 32'd0);
        rst_n = 1'b1;

        wr(14'h005, 8'hA5, 6'd0);
        wr(14'h705, 8'h3C, 6'd0);
        exp_q[0] = 8'h3C; rd_burst("rd_705", 14'h705, 8'd0);
        exp_q[0] = 8'hA5; rd_burst("rd_005", 14'h005, 8'd0);

        wr(14'h010, 8'h11, 6'd0);
        wr(14'h010, 8'h22, 6'd1);
        exp_q[0] = 8'h11; rd_burst("gated_wr", 14'h010, 8'd0);
        wr(14'h010, 8'h22, 6'd0);
        exp_q[0] = 8'h22; rd_burst("ungated_wr", 14'h010, 8'd0);

        wr(14'h0FE, 8'h01, 6'd0);
        wr(14'h0FF, 8'h02, 6'd0);
        wr(14'h100, 8'h03, 6'd0);
        wr(14'h101, 8'h04, 6'd0);
        exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'h04;
        rd_burst("bank_cross", 14'h0FE, 8'd3);

        wr(14'h7FF, 8'h77, 6'd0);
        wr(14'h000, 8'h88, 6'd0);
        exp_q[0] = 8'h77; exp_q[1] = 8'h88;
        rd_burst("wrap", 14'h7FF, 8'd1);

        // Upper reg_adr bits are ignored: 0x3805 aliases 0x005.
        exp_q[0] = 8'hA5; rd_burst("upper_ign", 14'h3805, 8'd0);

        // OUT_REG=1 instance: two-cycle latency.
        @(negedge clk);
        r_req_valid = 1'b1; r_we = 1'b1; r_reg_adr = 14'h3FF; r_din = 16'hBEEF;
        @(posedge clk);
        #1 r_req_valid = 1'b0; r_we = 1'b0;
        @(negedge clk);
        r_req_valid = 1'b1; r_burst_len = 8'd0;
        @(posedge clk);
        #1 r_req_valid = 1'b0;
        @(negedge clk);
        check_val("oreg_lat1_valid", 32'(r_rsp_valid), 32'd0);
        @(negedge clk);
        check_val("oreg_lat2_valid", 32'(r_rsp_valid), 32'd1);
        check_val("oreg_dout", 32'(r_dout), 32'hBEEF);
        @(negedge clk);
        check_val("oreg_after_valid", 32'(r_rsp_valid), 32'd0);
        check_val("oreg_hold", 32'(r_dout), 32'hBEEF);

        // Reset during the third beat of an 8-beat burst.
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; reg_adr = 14'h0FE; burst_len = 8'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midrst_beat3_valid", 32'(rsp_valid), 32'd1);
        check_val("midrst_beat3_dout", 32'(dout), 32'h03);
        check_val("midrst_beat3_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'h04;
        rd_burst("postrst_burst", 14'h0FE, 8'd3);
        exp_q[0] = 8'h3C; rd_burst("postrst_705", 14'h705, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
